instr_encoder: RTL and testbench

Sequential instruction encoder and program-memory writer: the inverse of the instruction decoder. It accepts symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake. Each one is packed into the exact 32-bit word format the decoder consumes and written to consecutive instruction-memory addresses. It terminates every program with the EXIT word (opcode 6'b111111). It sits between the host/test loader and instruction memory, ahead of the fetch/decode path.

---
 rtl/encoder_pkg.sv | 55 +++++
 rtl/instr_pack.sv | 71 +++++++
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared encoder/decoder definitions: mnemonic codes, opcode and funct values,
// the EXIT word, error codes and the encoder FSM state type.
package encoder_pkg;

   // Symbolic mnemonic codes presented on in_mnem; 25..31 are illegal.
   typedef enum logic [4:0] {
      MnAdd  = 5'd0,  MnAnd  = 5'd1,  MnJr   = 5'd2,  MnOr   = 5'd3,
      MnSll  = 5'd4,  MnSllv = 5'd5,  MnSrl  = 5'd6,  MnSrlv = 5'd7,
      MnSub  = 5'd8,  MnXor  = 5'd9,  MnAddi = 5'd10, MnAndi = 5'd11,
      MnBeq  = 5'd12, MnBgtz = 5'd13, MnBltz = 5'd14, MnBne  = 5'd15,
      MnJ    = 5'd16, MnJb   = 5'd17, MnJal  = 5'd18, MnLw   = 5'd19,
      MnOri  = 5'd20, MnSubi = 5'd21, MnSw   = 5'd22, MnXori = 5'd23,
      MnExit = 5'd24
   } mnem_e;

   // Primary opcodes (bits [31:26])
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBgtz  = 6'b000001;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpBltz  = 6'b000110;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSubi  = 6'b001001;
   localparam logic [5:0] OpSw    = 6'b001011;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;
   localparam logic [5:0] OpJb    = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpExit  = 6'b111111;

   // R-type funct codes (bits [5:0])
   localparam logic [5:0] FnSll  = 6'b000000;
   localparam logic [5:0] FnSrl  = 6'b000010;
   localparam logic [5:0] FnSllv = 6'b000100;
   localparam logic [5:0] FnSrlv = 6'b000110;
   localparam logic [5:0] FnJr   = 6'b001000;
   localparam logic [5:0] FnAdd  = 6'b100000;
   localparam logic [5:0] FnSub  = 6'b100010;
   localparam logic [5:0] FnAnd  = 6'b100100;
   localparam logic [5:0] FnOr   = 6'b100101;
   localparam logic [5:0] FnXor  = 6'b100110;

   localparam logic [31:0] ExitWord = {OpExit, 26'd0};

   localparam logic [1:0] ErrNone     = 2'd0;
   localparam logic [1:0] ErrIllegal  = 2'd1;
   localparam logic [1:0] ErrRange    = 2'd2;
   localparam logic [1:0] ErrOverflow = 2'd3;

   typedef enum logic [1:0] {StIdle, StEncode, StWrite, StDone} state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns one symbolic instruction into the 32-bit
// word the decoder consumes and flags illegal mnemonics / out-of-range fields.
// Ports:
//   mnem_i, rs_i, rt_i, rd_i, imm_i : symbolic instruction fields
//   word_o                          : packed instruction word
//   range_err_o                     : immediate does not fit its field
//   illegal_o                       : mnemonic code 25..31
module instr_pack
   import encoder_pkg::*;
(
   input  logic [4:0]  mnem_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [25:0] imm_i,
   output logic [31:0] word_o,
   output logic        range_err_o,
   output logic        illegal_o
);

   logic        imm_hi_nz;    // immediate does not zero-extend from 16 bits
   logic        shamt_hi_nz;  // shift amount does not fit 5 bits
   logic [25:0] imm_mag;      // magnitude of a negative J distance

   assign imm_hi_nz   = |imm_i[25:16];
   assign shamt_hi_nz = |imm_i[25:5];
   assign imm_mag     = ~imm_i + 26'd1;

   always_comb begin
      word_o      = '0;
      range_err_o = 1'b0;
      illegal_o   = 1'b0;
      case (mnem_i)
         MnAdd:  word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnAdd};
         MnAnd:  word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnAnd};
         MnOr:   word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnOr};
         MnSub:  word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnSub};
         MnXor:  word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnXor};
         MnJr:   word_o = {OpRtype, rs_i, rt_i, rd_i, 5'd0, FnJr};
         // Shift amount goes in [25:21], source register in [20:16]
         MnSll: begin
            word_o      = {OpRtype, imm_i[4:0], rs_i, rd_i, 5'd0, FnSll};
            range_err_o = shamt_hi_nz;
         end
         MnSrl: begin
            word_o      = {OpRtype, imm_i[4:0], rs_i, rd_i, 5'd0, FnSrl};
            range_err_o = shamt_hi_nz;
         end
         MnSllv: word_o = {OpRtype, rt_i, rs_i, rd_i, 5'd0, FnSllv};
         MnSrlv: word_o = {OpRtype, rt_i, rs_i, rd_i, 5'd0, FnSrlv};
         MnAddi: begin word_o = {OpAddi, rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnAndi: begin word_o = {OpAndi, rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnBeq:  begin word_o = {OpBeq,  rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnBne:  begin word_o = {OpBne,  rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnLw:   begin word_o = {OpLw,   rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnOri:  begin word_o = {OpOri,  rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnSubi: begin word_o = {OpSubi, rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnSw:   begin word_o = {OpSw,   rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnXori: begin word_o = {OpXori, rs_i, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnBgtz: begin word_o = {OpBgtz, rs_i, 5'd0, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnBltz: begin word_o = {OpBltz, rs_i, 5'd0, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         MnJal:  begin word_o = {OpJal,  5'd0, rt_i, imm_i[15:0]}; range_err_o = imm_hi_nz; end
         // Backward jumps are re-encoded as JB with a positive magnitude
         MnJ:    word_o = imm_i[25] ? {OpJb, imm_mag} : {OpJ, imm_i};
         MnJb:   word_o = {OpJb, imm_i};
         MnExit: word_o = ExitWord;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / program-memory writer. Accepts symbolic
// instructions over valid/ready, packs them and writes them to consecutive
// addresses; every program ends with the EXIT word.
// Ports:
//   CLOCK_50, reset           : clock, asynchronous active-high reset
//   start                     : restart at address 0 (honoured in IDLE/DONE)
//   in_valid/in_ready, in_*   : request handshake and symbolic fields
//   mem_wr_en/addr/wdata      : instruction-memory write port
//   busy, done, err, err_code : status
//   word_count                : words written since start, EXIT included
module instr_encoder
   import encoder_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [25:0]       in_imm,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count
);

   state_e              state_q, state_d;
   logic [4:0]          mnem_q, rs_q, rt_q, rd_q;
   logic [25:0]         imm_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     word_count_q;
   logic                mem_wr_en_q, err_q, exit_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [1:0]          err_code_q;

   logic [31:0]         pk_word;
   logic                pk_range_err, pk_illegal;
   logic                start_ok, accept, at_last, overflow, reject, wr_exit;

   instr_pack u_pack (
      .mnem_i      (mnem_q),
      .rs_i        (rs_q),
      .rt_i        (rt_q),
      .rd_i        (rd_q),
      .imm_i       (imm_q),
      .word_o      (pk_word),
      .range_err_o (pk_range_err),
      .illegal_o   (pk_illegal)
   );

   assign start_ok = start && (state_q == StIdle || state_q == StDone);
   // start wins over a simultaneous request
   assign accept   = in_valid && (state_q == StIdle) && !start;

   // The last slot is reserved for EXIT; any other request there overflows
   assign at_last  = (addr_q == ADDR_W'(DEPTH - 1));
   assign overflow = at_last && (mnem_q != MnExit);
   assign reject   = !overflow && (pk_illegal || pk_range_err);
   assign wr_exit  = overflow || (mnem_q == MnExit);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StEncode;
         StEncode: state_d = StWrite;
         StWrite:  state_d = exit_q ? StDone : StIdle;
         StDone:   if (start) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         mnem_q       <= '0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         imm_q        <= '0;
         addr_q       <= '0;
         word_count_q <= '0;
         mem_wr_en_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         err_q        <= 1'b0;
         err_code_q   <= ErrNone;
         exit_q       <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below
         mem_wr_en_q <= 1'b0;
         err_q       <= 1'b0;
         if (start_ok) begin
            addr_q       <= '0;
            word_count_q <= '0;
            err_code_q   <= ErrNone;
         end else if (accept) begin
            mnem_q     <= in_mnem;
            rs_q       <= in_rs;
            rt_q       <= in_rt;
            rd_q       <= in_rd;
            imm_q      <= in_imm;
            err_code_q <= ErrNone;
         end else if (state_q == StEncode) begin
            exit_q <= wr_exit;
            if (reject) begin
               err_q      <= 1'b1;
               err_code_q <= pk_illegal ? ErrIllegal : ErrRange;
            end else begin
               mem_wr_en_q  <= 1'b1;
               mem_addr_q   <= addr_q;
               mem_wdata_q  <= overflow ? ExitWord : pk_word;
               word_count_q <= word_count_q + (ADDR_W + 1)'(1);
               if (overflow) begin
                  err_q      <= 1'b1;
                  err_code_q <= ErrOverflow;
               end
               // Saturate rather than wrap at the last address
               if (!at_last) addr_q <= addr_q + ADDR_W'(1);
            end
         end
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign busy       = (state_q == StEncode) || (state_q == StWrite);
   assign done       = (state_q == StDone);
   assign mem_wr_en  = mem_wr_en_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4 so overflow is reachable).
// Expected memory writes go into a scoreboard queue when a request is driven
// and are popped when the DUT strobes mem_wr_en.
module tb_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   localparam logic [4:0] MAdd = 5'd0,  MSll = 5'd4,  MAddi = 5'd10, MBgtz = 5'd13;
   localparam logic [4:0] MJ   = 5'd16, MJal = 5'd18, MOri  = 5'd20, MExit = 5'd24;
   localparam logic [31:0] Exit = 32'hFC00_0000;

   logic              clk = 1'b0;
   logic              reset, start, in_valid, in_ready;
   logic [4:0]        in_mnem, in_rs, in_rt, in_rd;
   logic [25:0]       in_imm;
   logic              mem_wr_en, busy, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   word_count;

   int                n_checks = 0;
   int                n_pass   = 0;
   logic [39:0]       sb_q[$];
   logic [39:0]       sb_e;
   logic [ADDR_W-1:0] exp_addr;
   int                exp_count;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mnem    (in_mnem),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_imm     (in_imm),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .word_count (word_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Scoreboard consumer
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_write", 32'(mem_wr_en), 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            check_eq("wr_addr", 32'(mem_addr), 32'(sb_e[39:32]));
            check_eq("wr_data", mem_wdata, sb_e[31:0]);
         end
      end
   end

   task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, input bit exp_wr,
                       input logic [31:0] exp_data, input logic [1:0] exp_code);
      int guard;
      bit exp_done;
      guard = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check_eq("ready_wait", 32'(in_ready), 32'd1);
      in_mnem  = mn;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_imm   = imm;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (exp_wr) begin
         sb_q.push_back({exp_addr, exp_data});
         exp_count++;
         if (exp_addr != ADDR_W'(DEPTH - 1)) exp_addr++;
      end
      @(negedge clk);  // cycle 1: ENCODE
      check_eq("busy_encode", 32'(busy), 32'd1);
      @(negedge clk);  // cycle 2: WRITE / error pulse
      if (!exp_wr) check_eq("err_pulse", 32'(err), 32'd1);
      check_eq("err_code", 32'(err_code), 32'(exp_code));
      check_eq("word_count", 32'(word_count), 32'(exp_count));
      @(negedge clk);  // cycle 3: back to IDLE or DONE
      if (!exp_wr) check_eq("err_clear", 32'(err), 32'd0);
      exp_done = exp_wr && (exp_data == Exit);
      check_eq("done", 32'(done), 32'(exp_done));
      check_eq("ready_after", 32'(in_ready), 32'(!exp_done));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_addr  = '0;
      exp_count = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
      exp_addr = '0; exp_count = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", {30'd0, err_code}, 32'd0);
      check_eq("rst_count", 32'(word_count), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);

      send(MAdd, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1820, 2'd0);
      send(MJal, 5'd9, 5'd31, 5'd0, 26'h1234, 1'b1, 32'h0C1F_1234, 2'd0);

      pulse_start();
      send(MAddi, 5'd4, 5'd5, 5'd0, 26'h0010, 1'b1, 32'h2085_0010, 2'd0);
      send(MSll, 5'd7, 5'd0, 5'd8, 26'd3, 1'b1, 32'h0067_4000, 2'd0);
      send(MOri, 5'd1, 5'd2, 5'd0, 26'h10000, 1'b0, 32'd0, 2'd2);
      send(5'd27, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'd0, 2'd1);
      send(MJ, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFB, 1'b1, 32'h3C00_0005, 2'd0);

      pulse_start();
      send(MJ, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0800_0000, 2'd0);
      send(MBgtz, 5'd3, 5'd9, 5'd0, 26'h0020, 1'b1, 32'h0460_0020, 2'd0);
      send(MAdd, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1820, 2'd0);
      // Non-EXIT at the last address: EXIT goes there instead
      send(MAdd, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, Exit, 2'd3);

      pulse_start();
      @(negedge clk);
      check_eq("start_done", 32'(done), 32'd0);
      check_eq("start_count", 32'(word_count), 32'd0);
      check_eq("start_err", {30'd0, err_code}, 32'd0);

      // start and in_valid together: request must be dropped
      start = 1'b1; in_valid = 1'b1; in_mnem = MAdd;
      @(posedge clk);
      #1 start = 1'b0; in_valid = 1'b0;
      check_eq("start_wins_busy", 32'(busy), 32'd0);
      check_eq("start_wins_ready", 32'(in_ready), 32'd1);
      repeat (3) @(negedge clk);
      send(MAdd, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1820, 2'd0);

      // Reset asserted inside the WRITE cycle
      @(negedge clk);
      in_mnem = MAdd; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_imm = '0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 check_eq("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
      check_eq("rst_mid_ready", 32'(in_ready), 32'd1);
      check_eq("rst_mid_count", 32'(word_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_addr = '0; exp_count = 0;

      send(MExit, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, Exit, 2'd0);

      repeat (2) @(negedge clk);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
